regvfile_param: RTL and testbench
=================================

# regvfile_param

Parametrised vector register file for the vector datapath: `NREGS` registers of `LANES` signed elements, each `EW` bits wide. It supports:
- whole-vector writes with a per-lane mask, and single-element writes;
- two registered read ports with write-first forwarding;
- a multi-cycle bulk-clear sequencer.

It sits between decode/writeback and the vector ALU, replacing the fixed 8×9×9 file.

## Interface
Parameters:
- `LANES`, 9, elements per vector
- `EW`, 9, element width in bits (signed two's complement)
- `NREGS`, 8, number of vector registers
- `AW`, `$clog2(NREGS)` (min 1), register address width
- `IW`, `$clog2(LANES)` (min 1), element index width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wev`  in  1  vector write enable
- `wmask`  in  LANES  per-lane write mask for `wev`, bit i → lane i
- `wee`  in  1  element write enable
- `wa`  in  AW  write register address (both write types)
- `index`  in  IW  element index for `wee`
- `wdv`  in  LANES×EW signed  vector write data
- `wde`  in  EW signed  element write data
- `ra1`, `ra2`  in  AW  read addresses
- `rd1`, `rd2`  out  LANES×EW signed  registered read data
- `clr_req`  in  1  request bulk clear of all registers
- `clr_busy`  out  1  clear sequence in progress
- `clr_done`  out  1  one-cycle pulse when clear completes
- `wr_drop`  out  1  one-cycle pulse: a write request was discarded
- `addr_err`  out  1  sticky: out-of-range `wa`, `ra1`, `ra2` or `index` seen

## Operation
- Reset (`rst_n`=0, async) sets:
  - all register elements, `rd1`, `rd2` to 0;
  - `clr_busy`, `clr_done`, `wr_drop`, `addr_err` to 0;
  - FSM to IDLE.
- Write priority: `wev` over `wee`.
- Vector write: lanes with `wmask[i]`=1 load `wdv[i]`; other lanes hold.
- Element write: lane `index` of register `wa` loads `wde`.
- Out-of-range accesses:
  - `wa`≥NREGS or (`wee` and `index`≥LANES): write discarded, `wr_drop` pulses, `addr_err` set.
  - `ra`≥NREGS: that port returns 0 and sets `addr_err`.
  - `addr_err` clears only on reset.
- Reads are registered.
  - `rdN` at edge E = contents of `raN` after all writes committing at edge E (write-first forwarding, per lane, mask-aware).
  - Both ports may read the same address.
- Clear FSM:
  - IDLE: `clr_req`=1 at an edge → SWEEP with counter k=0.
  - SWEEP: each edge zeroes register k, then k++. After zeroing k=NREGS-1 → DONE.
  - DONE: one cycle, `clr_done`=1 → IDLE.
  - `clr_busy`=1 in SWEEP and DONE.
  - `clr_req` while busy is ignored. A new request in the cycle after DONE is accepted.
- Writes during SWEEP/DONE are discarded with `wr_drop` pulsing; `addr_err` is unaffected.
- Reads during SWEEP return current contents, with forwarding of the zeroing: a read of register k in its clear cycle returns 0.
- Reset mid-SWEEP: all registers 0 immediately, FSM to IDLE, no `clr_done`.
- No arithmetic on data; elements stored bit-exact, sign preserved.

## Timing
- Write latency: data written at edge E is readable on `rdN` registered at edge E (forwarded) and thereafter.
- Read latency: address presented in cycle C → data on `rdN` after edge ending C (1 cycle).
- Clear: request accepted at edge E0.
  - `clr_busy` high from E0 through the edge after the last zeroing edge.
  - Register k is zeroed at edge E0+1+k.
  - `clr_done` is high for the cycle following edge E0+NREGS.
  - Total busy = NREGS+1 cycles.
- `wr_drop`: high for the one cycle following the edge at which the write was rejected.
- `clr_done`: high for the one cycle following the edge at which the write was rejected? No: `clr_done` is governed only by the clear timing above.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset then vector write: `wa`=0, `wdv`=1..9, `wmask`=all 1s, then `ra1`=0 → `rd1`=1..9 one cycle later; all other registers read 0.
- Masked and element writes: `wa`=1, `wmask`=9'b000010101, `wdv`=all −3, then `wee`, `index`=5, `wde`=−5 → reg1 = {−3,0,−3,0,−3,−5,0,0,0} (lane 0 first); `wev`+`wee` in the same cycle applies only the vector write.
- Forwarding: write `wa`=2 `wdv`=all 7 while `ra1`=`ra2`=2 in the same cycle → both `rd` = all 7 at that edge, not the old value.
- Bulk clear: fill all 8 registers, pulse `clr_req` → `clr_busy` high 9 cycles, reg k reads 0 from edge E0+1+k, `clr_done` one cycle. A `wev` during SWEEP → `wr_drop` pulse, data unchanged.
- Errors: `wee` with `index`=9 (LANES=9) → no change, `wr_drop` pulse, `addr_err`=1 persisting until `rst_n` low.
- Async reset mid-SWEEP (k=3): outputs 0 without a clock edge; FSM IDLE; no `clr_done`.
- Re-run the first and third scenarios with `LANES`=4, `EW`=16, `NREGS`=16.

Source files
------------

// File: rtl/regvfile_param.sv
// Vector register file: NREGS x LANES signed elements of EW bits, masked vector and
// single-element writes, two registered write-first read ports, and a bulk-clear sequencer.
module regvfile_param #(
    parameter int LANES = 9,
    parameter int EW    = 9,
    parameter int NREGS = 8,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1,
    parameter int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wev,
    input  logic [LANES-1:0]               wmask,
    input  logic                           wee,
    input  logic [AW-1:0]                  wa,
    input  logic [IW-1:0]                  index,
    input  logic signed [LANES-1:0][EW-1:0] wdv,
    input  logic signed [EW-1:0]           wde,
    input  logic [AW-1:0]                  ra1,
    input  logic [AW-1:0]                  ra2,
    output logic signed [LANES-1:0][EW-1:0] rd1,
    output logic signed [LANES-1:0][EW-1:0] rd2,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic                           clr_done,
    output logic                           wr_drop,
    output logic                           addr_err,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} clr_state_t;

    clr_state_t state, state_nxt;
    logic [AW-1:0] clr_k, clr_k_nxt;

    logic [LANES-1:0][EW-1:0] mem     [NREGS];
    logic [LANES-1:0][EW-1:0] mem_nxt [NREGS];

    logic wr_req, busy, addr_ok, wr_ok, ra1_ok, ra2_ok;

    assign dbg_state = state;
    assign busy      = (state != IDLE);
    assign wr_req    = wev | wee;
    // The element index only matters when the element write is the one taking effect.
    assign addr_ok   = (int'(wa) < NREGS) && (wev || (int'(index) < LANES));
    assign wr_ok     = wr_req && !busy && addr_ok;
    assign ra1_ok    = (int'(ra1) < NREGS);
    assign ra2_ok    = (int'(ra2) < NREGS);

    // Clear handshake: clr_req is sampled on each rising edge; it is taken only while
    // clr_busy is low, and is silently ignored while clr_busy is high.
    always_comb begin
        state_nxt = state;
        clr_k_nxt = clr_k;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = SWEEP;
                    clr_k_nxt = '0;
                end
            end
            SWEEP: begin
                if (clr_k == AW'(NREGS - 1)) begin
                    state_nxt = DONE;
                end else begin
                    clr_k_nxt = clr_k + AW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Contents after this edge; the read ports sample these to get write-first forwarding.
    always_comb begin
        mem_nxt = mem;
        if (wr_ok) begin
            if (wev) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask[i]) mem_nxt[wa][i] = wdv[i];
                end
            end else begin
                mem_nxt[wa][index] = wde;
            end
        end
        if (state == SWEEP) mem_nxt[clr_k] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_k    <= '0;
            mem      <= '{default: '0};
            rd1      <= '0;
            rd2      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_drop  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_k    <= clr_k_nxt;
            mem      <= mem_nxt;
            rd1      <= ra1_ok ? mem_nxt[ra1] : '0;
            rd2      <= ra2_ok ? mem_nxt[ra2] : '0;
            clr_busy <= (state_nxt != IDLE);
            clr_done <= (state_nxt == DONE);
            wr_drop  <= wr_req && !wr_ok;
            // Writes rejected for being busy do not count as address errors.
            if ((wr_req && !busy && !addr_ok) || !ra1_ok || !ra2_ok) addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regvfile_param.sv
// Directed bench for regvfile_param: default 9x9x8 instance plus a 4x16x16 instance.
module tb_regvfile_param;

    localparam int LA = 9;
    localparam int EA = 9;
    localparam int NA = 8;
    localparam int LB = 4;
    localparam int EB = 16;
    localparam int NB = 16;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    // Instance A signals
    logic                    wev_a, wee_a, clr_req_a;
    logic [LA-1:0]           wmask_a;
    logic [2:0]              wa_a, ra1_a, ra2_a;
    logic [3:0]              index_a;
    logic signed [LA-1:0][EA-1:0] wdv_a, rd1_a, rd2_a;
    logic signed [EA-1:0]    wde_a;
    logic                    clr_busy_a, clr_done_a, wr_drop_a, addr_err_a;
    logic [1:0]              dbg_state_a;

    // Instance B signals
    logic                    wev_b, wee_b, clr_req_b;
    logic [LB-1:0]           wmask_b;
    logic [3:0]              wa_b, ra1_b, ra2_b;
    logic [1:0]              index_b;
    logic signed [LB-1:0][EB-1:0] wdv_b, rd1_b, rd2_b;
    logic signed [EB-1:0]    wde_b;
    logic                    clr_busy_b, clr_done_b, wr_drop_b, addr_err_b;
    logic [1:0]              dbg_state_b;

    logic [LA-1:0][EA-1:0] exp_a;
    logic [LB-1:0][EB-1:0] exp_b;

    regvfile_param #(.LANES(LA), .EW(EA), .NREGS(NA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wev(wev_a), .wmask(wmask_a), .wee(wee_a),
        .wa(wa_a), .index(index_a), .wdv(wdv_a), .wde(wde_a),
        .ra1(ra1_a), .ra2(ra2_a), .rd1(rd1_a), .rd2(rd2_a),
        .clr_req(clr_req_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a),
        .wr_drop(wr_drop_a), .addr_err(addr_err_a), .dbg_state(dbg_state_a)
    );

    regvfile_param #(.LANES(LB), .EW(EB), .NREGS(NB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wev(wev_b), .wmask(wmask_b), .wee(wee_b),
        .wa(wa_b), .index(index_b), .wdv(wdv_b), .wde(wde_b),
        .ra1(ra1_b), .ra2(ra2_b), .rd1(rd1_b), .rd2(rd2_b),
        .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
        .wr_drop(wr_drop_b), .addr_err(addr_err_b), .dbg_state(dbg_state_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_inputs();
        wev_a = 1'b0; wee_a = 1'b0; clr_req_a = 1'b0; wmask_a = '0;
        wa_a = '0; ra1_a = '0; ra2_a = '0; index_a = '0; wdv_a = '0; wde_a = '0;
        wev_b = 1'b0; wee_b = 1'b0; clr_req_b = 1'b0; wmask_b = '0;
        wa_b = '0; ra1_b = '0; ra2_b = '0; index_b = '0; wdv_b = '0; wde_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EA-1:0] fill_val(int r, int l);
        return EA'((r + 1) * 10 + l);
    endfunction

    task automatic fill_all_a();
        for (int r = 0; r < NA; r++) begin
            @(negedge clk);
            wev_a = 1'b1; wa_a = 3'(r); wmask_a = '1;
            for (int l = 0; l < LA; l++) wdv_a[l] = fill_val(r, l);
        end
        @(negedge clk);
        wev_a = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({rd1_a, rd2_a} !== '0) begin
            miscompares++; $display("FAIL reset_rd got %h %h exp 0", rd1_a, rd2_a);
        end
        vectors++;
        if ({clr_busy_a, clr_done_a, wr_drop_a, addr_err_a, dbg_state_a} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags got busy=%b done=%b drop=%b err=%b st=%0d exp all 0",
                     clr_busy_a, clr_done_a, wr_drop_a, addr_err_a, dbg_state_a);
        end
    endtask

    task automatic test_vector_write();
        @(negedge clk);
        wev_a = 1'b1; wa_a = 3'd0; wmask_a = '1;
        for (int l = 0; l < LA; l++) wdv_a[l] = EA'(l + 1);
        @(negedge clk);
        wev_a = 1'b0; ra1_a = 3'd0;
        tick();
        for (int l = 0; l < LA; l++) exp_a[l] = EA'(l + 1);
        vectors++;
        if (rd1_a !== exp_a) begin
            miscompares++; $display("FAIL vec_write got %h exp %h", rd1_a, exp_a);
        end
        for (int r = 1; r < NA; r++) begin
            @(negedge clk);
            ra1_a = 3'(r); ra2_a = 3'(r);
            tick();
            vectors++;
            if ({rd1_a, rd2_a} !== '0) begin
                miscompares++; $display("FAIL other_reg_zero r=%0d got %h %h exp 0", r, rd1_a, rd2_a);
            end
        end
    endtask

    task automatic test_masked_element();
        @(negedge clk);
        wev_a = 1'b1; wa_a = 3'd1; wmask_a = 9'b000010101;
        for (int l = 0; l < LA; l++) wdv_a[l] = EA'(-3);
        @(negedge clk);
        wev_a = 1'b0; wee_a = 1'b1; index_a = 4'd5; wde_a = EA'(-5);
        @(negedge clk);
        wee_a = 1'b0; ra1_a = 3'd1;
        tick();
        exp_a = '0;
        exp_a[0] = EA'(-3); exp_a[2] = EA'(-3); exp_a[4] = EA'(-3); exp_a[5] = EA'(-5);
        vectors++;
        if (rd1_a !== exp_a) begin
            miscompares++; $display("FAIL mask_elem got %h exp %h", rd1_a, exp_a);
        end
        // Vector and element write together: only the vector write lands.
        @(negedge clk);
        wev_a = 1'b1; wee_a = 1'b1; wa_a = 3'd1; wmask_a = 9'b000000010;
        for (int l = 0; l < LA; l++) wdv_a[l] = EA'(4);
        index_a = 4'd0; wde_a = EA'(11);
        tick();
        exp_a[1] = EA'(4);
        vectors++;
        if (rd1_a !== exp_a) begin
            miscompares++; $display("FAIL wev_over_wee got %h exp %h", rd1_a, exp_a);
        end
        vectors++;
        if (wr_drop_a !== 1'b0) begin
            miscompares++; $display("FAIL wev_over_wee_drop got %b exp 0", wr_drop_a);
        end
        @(negedge clk);
        wev_a = 1'b0; wee_a = 1'b0;
    endtask

    task automatic test_forward();
        @(negedge clk);
        wev_a = 1'b1; wa_a = 3'd2; wmask_a = '1; ra1_a = 3'd0; ra2_a = 3'd0;
        for (int l = 0; l < LA; l++) wdv_a[l] = EA'(1);
        @(negedge clk);
        ra1_a = 3'd2; ra2_a = 3'd2;
        for (int l = 0; l < LA; l++) wdv_a[l] = EA'(7);
        tick();
        for (int l = 0; l < LA; l++) exp_a[l] = EA'(7);
        vectors++;
        if (rd1_a !== exp_a || rd2_a !== exp_a) begin
            miscompares++; $display("FAIL forward got %h %h exp %h", rd1_a, rd2_a, exp_a);
        end
        @(negedge clk);
        wev_a = 1'b0;
    endtask

    task automatic test_error();
        @(negedge clk);
        wee_a = 1'b1; wa_a = 3'd0; index_a = 4'd9; wde_a = EA'(5); ra1_a = 3'd0;
        tick();
        for (int l = 0; l < LA; l++) exp_a[l] = EA'(l + 1);
        vectors++;
        if (rd1_a !== exp_a) begin
            miscompares++; $display("FAIL bad_index_data got %h exp %h", rd1_a, exp_a);
        end
        vectors++;
        if (wr_drop_a !== 1'b1 || addr_err_a !== 1'b1) begin
            miscompares++; $display("FAIL bad_index_flags got drop=%b err=%b exp 1 1", wr_drop_a, addr_err_a);
        end
        @(negedge clk);
        wee_a = 1'b0;
        tick();
        vectors++;
        if (wr_drop_a !== 1'b0 || addr_err_a !== 1'b1) begin
            miscompares++; $display("FAIL err_sticky got drop=%b err=%b exp 0 1", wr_drop_a, addr_err_a);
        end
    endtask

    task automatic test_bulk_clear();
        logic [LA-1:0][EA-1:0] exp2;
        fill_all_a();
        clr_req_a = 1'b1; ra1_a = 3'd0; ra2_a = 3'd0;
        tick();
        vectors++;
        if (clr_busy_a !== 1'b1 || clr_done_a !== 1'b0) begin
            miscompares++; $display("FAIL clr_accept got busy=%b done=%b exp 1 0", clr_busy_a, clr_done_a);
        end
        for (int k = 0; k < NA; k++) begin
            @(negedge clk);
            clr_req_a = (k == 4);
            ra1_a = 3'(k); ra2_a = 3'((k + 1) % NA);
            if (k == 2) begin
                wev_a = 1'b1; wa_a = 3'd7; wmask_a = '1;
                for (int l = 0; l < LA; l++) wdv_a[l] = EA'(99);
            end else begin
                wev_a = 1'b0;
            end
            tick();
            for (int l = 0; l < LA; l++) exp2[l] = (k + 1 < NA) ? fill_val(k + 1, l) : '0;
            vectors++;
            if (rd1_a !== '0 || rd2_a !== exp2) begin
                miscompares++; $display("FAIL sweep_k%0d got %h %h exp 0 %h", k, rd1_a, rd2_a, exp2);
            end
            vectors++;
            if (clr_busy_a !== 1'b1 || clr_done_a !== (k == NA - 1) || wr_drop_a !== (k == 2)) begin
                miscompares++;
                $display("FAIL sweep_flags_k%0d got busy=%b done=%b drop=%b exp 1 %b %b",
                         k, clr_busy_a, clr_done_a, wr_drop_a, k == NA - 1, k == 2);
            end
        end
        @(negedge clk);
        clr_req_a = 1'b0; wev_a = 1'b0;
        tick();
        vectors++;
        if (clr_busy_a !== 1'b0 || clr_done_a !== 1'b0) begin
            miscompares++; $display("FAIL clr_end got busy=%b done=%b exp 0 0", clr_busy_a, clr_done_a);
        end
        @(negedge clk);
        clr_req_a = 1'b1;
        tick();
        vectors++;
        if (clr_busy_a !== 1'b1) begin
            miscompares++; $display("FAIL clr_rerequest got busy=%b exp 1", clr_busy_a);
        end
        @(negedge clk);
        clr_req_a = 1'b0;
        repeat (NA + 1) @(posedge clk);
        #1;
        vectors++;
        if (clr_busy_a !== 1'b0) begin
            miscompares++; $display("FAIL clr_rerun_end got busy=%b exp 0", clr_busy_a);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        fill_all_a();
        clr_req_a = 1'b1;
        tick();
        @(negedge clk);
        clr_req_a = 1'b0; ra1_a = 3'd5; ra2_a = 3'd6;
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < LA; l++) exp_a[l] = fill_val(5, l);
        vectors++;
        if (rd1_a !== exp_a || clr_busy_a !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset got %h busy=%b exp %h 1", rd1_a, clr_busy_a, exp_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rd1_a !== '0 || rd2_a !== '0) begin
            miscompares++; $display("FAIL async_reset_rd got %h %h exp 0", rd1_a, rd2_a);
        end
        vectors++;
        if ({clr_busy_a, clr_done_a, addr_err_a, dbg_state_a} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset_flags got busy=%b done=%b err=%b st=%0d exp all 0",
                     clr_busy_a, clr_done_a, addr_err_a, dbg_state_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < NA + 3; c++) begin
            tick();
            if (clr_done_a !== 1'b0 || clr_busy_a !== 1'b0) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++; $display("FAIL no_done_after_reset got %0d active cycles exp 0", done_seen);
        end
        vectors++;
        if (rd1_a !== '0 || rd2_a !== '0) begin
            miscompares++; $display("FAIL regs_zero_after_reset got %h %h exp 0", rd1_a, rd2_a);
        end
    endtask

    task automatic test_b_vector_write();
        @(negedge clk);
        wev_b = 1'b1; wa_b = 4'd0; wmask_b = '1;
        wdv_b[0] = EB'(1000); wdv_b[1] = EB'(-2000); wdv_b[2] = EB'(30000); wdv_b[3] = EB'(-32768);
        @(negedge clk);
        wev_b = 1'b0; ra1_b = 4'd0;
        tick();
        exp_b[0] = 16'h03E8; exp_b[1] = 16'hF830; exp_b[2] = 16'h7530; exp_b[3] = 16'h8000;
        vectors++;
        if (rd1_b !== exp_b) begin
            miscompares++; $display("FAIL b_vec_write got %h exp %h", rd1_b, exp_b);
        end
        for (int r = 1; r < NB; r++) begin
            @(negedge clk);
            ra1_b = 4'(r); ra2_b = 4'(r);
            tick();
            vectors++;
            if ({rd1_b, rd2_b} !== '0) begin
                miscompares++; $display("FAIL b_other_zero r=%0d got %h %h exp 0", r, rd1_b, rd2_b);
            end
        end
    endtask

    task automatic test_b_forward();
        @(negedge clk);
        wev_b = 1'b1; wa_b = 4'd15; wmask_b = '1; ra1_b = 4'd0; ra2_b = 4'd0;
        for (int l = 0; l < LB; l++) wdv_b[l] = EB'(16'h1111);
        @(negedge clk);
        ra1_b = 4'd15; ra2_b = 4'd15;
        for (int l = 0; l < LB; l++) wdv_b[l] = EB'(-7);
        tick();
        for (int l = 0; l < LB; l++) exp_b[l] = 16'hFFF9;
        vectors++;
        if (rd1_b !== exp_b || rd2_b !== exp_b) begin
            miscompares++; $display("FAIL b_forward got %h %h exp %h", rd1_b, rd2_b, exp_b);
        end
        vectors++;
        if (addr_err_b !== 1'b0 || wr_drop_b !== 1'b0) begin
            miscompares++; $display("FAIL b_top_reg_flags got err=%b drop=%b exp 0 0", addr_err_b, wr_drop_b);
        end
        @(negedge clk);
        wev_b = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_vector_write();
        test_masked_element();
        test_forward();
        test_error();
        test_bulk_clear();
        test_reset_mid_sweep();
        test_b_vector_write();
        test_b_forward();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
